// File: rtl/dmem_arbiter_if.sv
// Request/response and memory-side signals of the two-port data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned F3_W = 3;

    // requester side
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [F3_W-1:0]   f3_0;
    logic [F3_W-1:0]   f3_1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              done0;
    logic              done1;
    logic              err0;
    logic              err1;
    logic [DATA_W-1:0] rdata;
    logic              busy;

    // memory side
    logic              m_read;
    logic              m_write;
    logic [ADDR_W-1:0] m_addr;
    logic [F3_W-1:0]   m_f3;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    // arbiter view
    modport slave (
        input  req0, req1, we0, we1, f3_0, f3_1, addr0, addr1, wdata0, wdata1,
        input  m_rdata,
        output done0, done1, err0, err1, rdata, busy,
        output m_read, m_write, m_addr, m_f3, m_wdata
    );

    // requesters plus memory view
    modport master (
        output req0, req1, we0, we1, f3_0, f3_1, addr0, addr1, wdata0, wdata1,
        output m_rdata,
        input  done0, done1, err0, err1, rdata, busy,
        input  m_read, m_write, m_addr, m_f3, m_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the shared byte-addressed data memory.
// Each access runs IDLE -> ACCESS -> DONE; memory strobes exist only in ACCESS.
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);
    localparam int unsigned F3_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic              id;
        logic              we;
        logic [F3_W-1:0]   f3;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              bad;
    } txn_t;

    state_t            state;
    state_t            state_nxt;
    txn_t              txn_q;
    txn_t              txn_c;
    logic              last_gnt;
    logic              any_req_c;
    logic              win_c;
    logic              grant_c;

    logic              done0_q;
    logic              done1_q;
    logic              err0_q;
    logic              err1_q;
    logic [DATA_W-1:0] rdata_q;
    logic              busy_q;

    logic              m_read_c;
    logic              m_write_c;
    logic [ADDR_W-1:0] m_addr_c;
    logic [F3_W-1:0]   m_f3_c;
    logic [DATA_W-1:0] m_wdata_c;

    // Illegal funct3 for the direction, or address not aligned to the access size.
    function automatic logic calc_bad(
        input logic              we,
        input logic [F3_W-1:0]   f3,
        input logic [ADDR_W-1:0] addr
    );
        logic illegal;
        logic misaligned;
        if (we) begin
            illegal = (f3 > 3'd2);
        end else begin
            illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        case (f3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = |addr[1:0];
            default: misaligned = 1'b0;
        endcase
        return illegal | misaligned;
    endfunction

    // Winner selection (tie goes to the port that was not granted last) and payload mux.
    always_comb begin
        any_req_c = bus.req0 | bus.req1;
        if (bus.req0 && bus.req1) begin
            win_c = ~last_gnt;
        end else begin
            win_c = bus.req1;
        end
        txn_c.id    = win_c;
        txn_c.we    = win_c ? bus.we1    : bus.we0;
        txn_c.f3    = win_c ? bus.f3_1   : bus.f3_0;
        txn_c.addr  = win_c ? bus.addr1  : bus.addr0;
        txn_c.wdata = win_c ? bus.wdata1 : bus.wdata0;
        txn_c.bad   = calc_bad(txn_c.we, txn_c.f3, txn_c.addr);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and memory strobes; strobes decode from state so reset kills them at once.
    always_comb begin
        state_nxt = state;
        grant_c   = 1'b0;
        m_read_c  = 1'b0;
        m_write_c = 1'b0;
        m_addr_c  = '0;
        m_f3_c    = '0;
        m_wdata_c = '0;
        case (state)
            ST_IDLE: begin
                if (any_req_c) begin
                    grant_c   = 1'b1;
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                m_read_c  = ~txn_q.we & ~txn_q.bad;
                m_write_c =  txn_q.we & ~txn_q.bad;
                m_addr_c  = txn_q.addr;
                m_f3_c    = txn_q.f3;
                m_wdata_c = txn_q.wdata;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latch the granted request and remember who won for the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_q    <= '0;
            last_gnt <= 1'b1;
        end else if (grant_c) begin
            txn_q    <= txn_c;
            last_gnt <= win_c;
        end
    end

    // Completion pulse, error flag, load capture and busy, all timed off the ACCESS cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            done0_q <= (state == ST_ACCESS) & ~txn_q.id;
            done1_q <= (state == ST_ACCESS) &  txn_q.id;
            err0_q  <= (state == ST_ACCESS) & ~txn_q.id & txn_q.bad;
            err1_q  <= (state == ST_ACCESS) &  txn_q.id & txn_q.bad;
            busy_q  <= (state_nxt != ST_IDLE);
            if (state == ST_ACCESS) begin
                rdata_q <= (~txn_q.we & ~txn_q.bad) ? bus.m_rdata : '0;
            end
        end
    end

    assign bus.done0   = done0_q;
    assign bus.done1   = done1_q;
    assign bus.err0    = err0_q;
    assign bus.err1    = err1_q;
    assign bus.rdata   = rdata_q;
    assign bus.busy    = busy_q;
    assign bus.m_read  = m_read_c;
    assign bus.m_write = m_write_c;
    assign bus.m_addr  = m_addr_c;
    assign bus.m_f3    = m_f3_c;
    assign bus.m_wdata = m_wdata_c;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: byte memory behind the arbiter, per-port request queues,
// and a transaction-level reference (round-robin order, legality, byte-array memory).
module tb_dmem_arbiter;
    localparam int unsigned ADDR_W    = 6;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MEM_BYTES = 64;

    typedef struct packed {
        logic              we;
        logic [2:0]        f3;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } txn_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory attached to the arbiter: synchronous write, combinational read.
    logic [7:0]  mem [MEM_BYTES];
    logic [31:0] mem_word;

    always @(posedge clk) begin
        if (bus.m_write) begin
            mem[bus.m_addr] <= bus.m_wdata[7:0];
            if (bus.m_f3[1:0] != 2'b00) mem[ADDR_W'(bus.m_addr + 6'd1)] <= bus.m_wdata[15:8];
            if (bus.m_f3[1:0] == 2'b10) begin
                mem[ADDR_W'(bus.m_addr + 6'd2)] <= bus.m_wdata[23:16];
                mem[ADDR_W'(bus.m_addr + 6'd3)] <= bus.m_wdata[31:24];
            end
        end
    end

    always_comb begin
        mem_word = {mem[ADDR_W'(bus.m_addr + 6'd3)], mem[ADDR_W'(bus.m_addr + 6'd2)],
                    mem[ADDR_W'(bus.m_addr + 6'd1)], mem[bus.m_addr]};
        bus.m_rdata = '0;
        if (bus.m_read) begin
            case (bus.m_f3)
                3'b000:  bus.m_rdata = {{24{mem_word[7]}}, mem_word[7:0]};
                3'b001:  bus.m_rdata = {{16{mem_word[15]}}, mem_word[15:0]};
                3'b010:  bus.m_rdata = mem_word;
                3'b100:  bus.m_rdata = {24'h0, mem_word[7:0]};
                3'b101:  bus.m_rdata = {16'h0, mem_word[15:0]};
                default: bus.m_rdata = '0;
            endcase
        end
    end

    // Reference state
    logic [7:0]  ref_mem [MEM_BYTES];
    txn_t        q0[$];
    txn_t        q1[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          ecnt = 0;
    int          g = -100;
    logic        last = 1'b1;
    logic        cur_port = 1'b0;
    txn_t        cur = '0;
    logic        cur_bad = 1'b0;
    logic [31:0] cur_res = '0;
    logic [31:0] exp_rdata = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, ecnt);
        end
    endtask

    function automatic txn_t mk(input logic we, input logic [2:0] f3, input int addr, input logic [31:0] wd);
        txn_t t;
        t.we    = we;
        t.f3    = f3;
        t.addr  = ADDR_W'(addr);
        t.wdata = wd;
        return t;
    endfunction

    // Legal direction/funct3 pairs, and address a multiple of the access size.
    function automatic logic ref_bad(input txn_t t);
        bit legal;
        int size;
        if (t.we) legal = (t.f3 inside {3'd0, 3'd1, 3'd2});
        else      legal = (t.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size = 1 << t.f3[1:0];
        return !legal || ((int'(t.addr) % size) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input txn_t t);
        int size;
        logic [31:0] v;
        size = 1 << t.f3[1:0];
        v = '0;
        for (int i = 0; i < size; i++) v = v | (32'(ref_mem[ADDR_W'(int'(t.addr) + i)]) << (8 * i));
        if (!t.f3[2] && size < 4 && v[8 * size - 1]) v = v | (32'hFFFF_FFFF << (8 * size));
        return v;
    endfunction

    task automatic ref_store(input txn_t t);
        int size;
        size = 1 << t.f3[1:0];
        for (int i = 0; i < size; i++) ref_mem[ADDR_W'(int'(t.addr) + i)] = t.wdata[8 * i +: 8];
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        int sz;
        t.we = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) t.f3 = 3'($urandom_range(0, 7));
        else if (t.we) t.f3 = 3'($urandom_range(0, 2));
        else begin
            case ($urandom_range(0, 4))
                0:       t.f3 = 3'd0;
                1:       t.f3 = 3'd1;
                2:       t.f3 = 3'd2;
                3:       t.f3 = 3'd4;
                default: t.f3 = 3'd5;
            endcase
        end
        sz = 1 << t.f3[1:0];
        if (sz > 4) sz = 4;
        t.addr = ADDR_W'($urandom_range(0, MEM_BYTES - 1));
        if ($urandom_range(0, 3) != 0) t.addr = ADDR_W'((int'(t.addr) / sz) * sz);
        t.wdata = 32'($urandom);
        return t;
    endfunction

    // Present each queue head as a held request.
    task automatic drive_reqs();
        txn_t h0;
        txn_t h1;
        h0 = (q0.size() != 0) ? q0[0] : '0;
        h1 = (q1.size() != 0) ? q1[0] : '0;
        bus.req0   = (q0.size() != 0);
        bus.req1   = (q1.size() != 0);
        bus.we0    = h0.we;
        bus.we1    = h1.we;
        bus.f3_0   = h0.f3;
        bus.f3_1   = h1.f3;
        bus.addr0  = h0.addr;
        bus.addr1  = h1.addr;
        bus.wdata0 = h0.wdata;
        bus.wdata1 = h1.wdata;
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        last      = 1'b1;
        g         = -100;
        exp_rdata = '0;
        drive_reqs();
    endtask

    // One clock: predict a grant for the coming edge, then check every output.
    task automatic step();
        logic acc;
        logic dn;
        if ((ecnt + 1 >= g + 3) && (q0.size() != 0 || q1.size() != 0)) begin
            if (q0.size() != 0 && q1.size() != 0) cur_port = ~last;
            else cur_port = (q1.size() != 0);
            last    = cur_port;
            cur     = cur_port ? q1[0] : q0[0];
            cur_bad = ref_bad(cur);
            cur_res = (!cur.we && !cur_bad) ? ref_load(cur) : 32'h0;
            g       = ecnt + 1;
        end
        @(posedge clk);
        ecnt++;
        @(negedge clk);
        acc = (ecnt == g);
        dn  = (ecnt == g + 1);
        chk("busy",    32'(bus.busy),    32'(acc | dn));
        chk("m_read",  32'(bus.m_read),  32'(acc & ~cur.we & ~cur_bad));
        chk("m_write", 32'(bus.m_write), 32'(acc & cur.we & ~cur_bad));
        chk("m_addr",  32'(bus.m_addr),  acc ? 32'(cur.addr) : 32'h0);
        chk("m_f3",    32'(bus.m_f3),    acc ? 32'(cur.f3) : 32'h0);
        chk("m_wdata", bus.m_wdata,      acc ? cur.wdata : 32'h0);
        chk("done0",   32'(bus.done0),   32'(dn & ~cur_port));
        chk("done1",   32'(bus.done1),   32'(dn & cur_port));
        chk("err0",    32'(bus.err0),    32'(dn & ~cur_port & cur_bad));
        chk("err1",    32'(bus.err1),    32'(dn & cur_port & cur_bad));
        if (dn) begin
            exp_rdata = cur_res;
            if (cur.we && !cur_bad) ref_store(cur);
            if (cur_port) void'(q1.pop_front());
            else          void'(q0.pop_front());
        end
        chk("rdata", bus.rdata, exp_rdata);
        drive_reqs();
    endtask

    task automatic run_until_idle();
        int n;
        n = 0;
        drive_reqs();
        while ((q0.size() != 0 || q1.size() != 0 || ecnt <= g + 1) && n < 400) begin
            step();
            n++;
        end
        chk("idle_timeout", 32'(n < 400), 32'd1);
    endtask

    task automatic reset_cycles(input int n);
        rst_n = 1'b0;
        model_reset();
        repeat (n) begin
            @(posedge clk);
            ecnt++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < int'(MEM_BYTES); i++) ref_mem[i] = 8'h00;
        model_reset();
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk);
            ecnt++;
        end
        @(negedge clk);
        chk("rst_busy",    32'(bus.busy),    32'h0);
        chk("rst_done0",   32'(bus.done0),   32'h0);
        chk("rst_done1",   32'(bus.done1),   32'h0);
        chk("rst_err0",    32'(bus.err0),    32'h0);
        chk("rst_err1",    32'(bus.err1),    32'h0);
        chk("rst_rdata",   bus.rdata,        32'h0);
        chk("rst_m_read",  32'(bus.m_read),  32'h0);
        chk("rst_m_write", 32'(bus.m_write), 32'h0);
        chk("rst_m_addr",  32'(bus.m_addr),  32'h0);
        rst_n = 1'b1;

        // fill memory through the arbiter so every byte is defined
        for (int w = 0; w < int'(MEM_BYTES) / 4; w++) q0.push_back(mk(1'b1, 3'b010, 4 * w, 32'($urandom)));
        run_until_idle();

        // SW then LW on port 0
        q0.push_back(mk(1'b1, 3'b010, 8, 32'hDEAD_BEEF));
        q0.push_back(mk(1'b0, 3'b010, 8, 32'h0));
        run_until_idle();
        chk("t1_lw_rdata", bus.rdata, 32'hDEAD_BEEF);

        // sign- and zero-extended byte loads on port 1
        q1.push_back(mk(1'b1, 3'b000, 4, 32'h0000_0080));
        q1.push_back(mk(1'b0, 3'b000, 4, 32'h0));
        run_until_idle();
        chk("t2_lb_rdata", bus.rdata, 32'hFFFF_FF80);
        q1.push_back(mk(1'b0, 3'b100, 4, 32'h0));
        run_until_idle();
        chk("t2_lbu_rdata", bus.rdata, 32'h0000_0080);

        // both ports held from reset: strict alternation starting with port 0
        reset_cycles(2);
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk(1'b0, 3'b010, 4 * i, 32'h0));
            q1.push_back(mk(1'b0, 3'b101, 2 * i, 32'h0));
        end
        run_until_idle();

        // misaligned and illegal accesses
        q0.push_back(mk(1'b0, 3'b010, 6, 32'h0));
        q0.push_back(mk(1'b1, 3'b001, 3, 32'h1234_5678));
        q0.push_back(mk(1'b0, 3'b011, 0, 32'h0));
        run_until_idle();
        chk("t4_rdata", bus.rdata, 32'h0);

        // reset during the ACCESS cycle of a store
        q0.push_back(mk(1'b1, 3'b010, 12, 32'hA5A5_5A5A ^ 32'($urandom)));
        drive_reqs();
        for (int n = 0; n < 4 && ecnt != g; n++) step();
        chk("t5_m_write_pre", 32'(bus.m_write), 32'h1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t5_m_write", 32'(bus.m_write), 32'h0);
        chk("t5_busy",    32'(bus.busy),    32'h0);
        chk("t5_done0",   32'(bus.done0),   32'h0);
        chk("t5_rdata",   bus.rdata,        32'h0);
        @(posedge clk);
        ecnt++;
        @(negedge clk);
        rst_n = 1'b1;
        q1.push_back(mk(1'b0, 3'b010, 12, 32'h0));
        q0.push_back(mk(1'b0, 3'b010, 12, 32'h0));
        run_until_idle();

        // single port held for several requests
        for (int i = 0; i < 3; i++) q1.push_back(rand_txn());
        run_until_idle();

        // random traffic on both ports
        for (int c = 0; c < 1500; c++) begin
            if (q0.size() < 2 && $urandom_range(0, 2) == 0) q0.push_back(rand_txn());
            if (q1.size() < 2 && $urandom_range(0, 2) == 0) q1.push_back(rand_txn());
            drive_reqs();
            step();
        end
        run_until_idle();

        for (int w = 0; w < int'(MEM_BYTES) / 4; w++) begin
            chk("mem_word", {mem[4 * w + 3], mem[4 * w + 2], mem[4 * w + 1], mem[4 * w]},
                {ref_mem[4 * w + 3], ref_mem[4 * w + 2], ref_mem[4 * w + 1], ref_mem[4 * w]});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
